// File: rtl/alu_pkg.sv
// Shared definitions for the adder result stage: operand width, flag bit
// positions, the buffered result entry and the flag computation.
package alu_pkg;

  localparam int W = 5;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic [W:0]  sum;
    logic [3:0]  flags;
  } result_t;

  // Flags describe the W-bit two's-complement view of the sum; carry is S[W].
  function automatic logic [3:0] calc_flags(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W:0]   s);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = s[W];
    f[FLAG_Z] = (s[W-1:0] == '0);
    f[FLAG_N] = s[W-1];
    f[FLAG_V] = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return f;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small valid/ready FIFO of result entries; occupancy alone decides in_ready,
// so a pop never opens room for a push in the same cycle.
module result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  input  result_t in_data_i,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output result_t out_data_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  result_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= in_data_i;
  end

  // Storage is never reset; hide stale contents while empty.
  assign out_data_o = out_valid_o ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ripple adder: buffers sums with status
// flags, keeps saturating statistics and a sticky adder-mismatch flag.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W:0]       S,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [W:0]       OUT_S,
  output logic [3:0]       OUT_FLAGS,
  output logic [CNT_W-1:0] RES_CNT,
  output logic [CNT_W-1:0] CARRY_CNT,
  output logic [CNT_W-1:0] OVF_CNT,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  result_t          in_entry, out_entry;
  logic             push, mismatch;
  logic [W:0]       sum_ref;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             err_q, err_d;

  assign in_entry.sum   = S;
  assign in_entry.flags = calc_flags(A, B, S);
  assign sum_ref        = {1'b0, A} + {1'b0, B};
  assign mismatch       = (S != sum_ref);
  assign push           = IN_VALID && IN_READY;

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .in_valid_i  (IN_VALID),
    .in_ready_o  (IN_READY),
    .in_data_i   (in_entry),
    .out_valid_o (OUT_VALID),
    .out_ready_i (OUT_READY),
    .out_data_o  (out_entry)
  );

  // Clear takes effect first, so a same-cycle qualifying push lands on zero.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] q,
                                                input logic clr,
                                                input logic inc);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : q;
    return (inc && base != CNT_MAX) ? base + 1'b1 : base;
  endfunction

  always_comb begin
    res_cnt_d   = cnt_next(res_cnt_q, CLR, push);
    carry_cnt_d = cnt_next(carry_cnt_q, CLR, push && in_entry.flags[FLAG_C]);
    ovf_cnt_d   = cnt_next(ovf_cnt_q, CLR, push && in_entry.flags[FLAG_V]);
    err_d       = (CLR ? 1'b0 : err_q) | (push && mismatch);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_cnt_q   <= '0;
      carry_cnt_q <= '0;
      ovf_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      res_cnt_q   <= res_cnt_d;
      carry_cnt_q <= carry_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      err_q       <= err_d;
    end
  end

  assign OUT_S     = out_entry.sum;
  assign OUT_FLAGS = out_entry.flags;
  assign RES_CNT   = res_cnt_q;
  assign CARRY_CNT = carry_cnt_q;
  assign OVF_CNT   = ovf_cnt_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage; inputs change and outputs are
// sampled on the falling clock edge.
module tb_alu_result_stage;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CLR = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [4:0] A = '0;
  logic [4:0] B = '0;
  logic [5:0] S = '0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [5:0] OUT_S;
  logic [3:0] OUT_FLAGS;
  logic [7:0] RES_CNT, CARRY_CNT, OVF_CNT;
  logic       ERR;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CLR       (CLR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .S         (S),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_S     (OUT_S),
    .OUT_FLAGS (OUT_FLAGS),
    .RES_CNT   (RES_CNT),
    .CARRY_CNT (CARRY_CNT),
    .OVF_CNT   (OVF_CNT),
    .ERR       (ERR)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic [5:0] s);
    IN_VALID = v;
    A = a;
    B = b;
    S = s;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_val("rst_out_valid", OUT_VALID, 0);
    check_val("rst_in_ready", IN_READY, 1);
    check_val("rst_out_s", OUT_S, 0);
    check_val("rst_flags", OUT_FLAGS, 0);
    check_val("rst_res_cnt", RES_CNT, 0);
    check_val("rst_carry_cnt", CARRY_CNT, 0);
    check_val("rst_ovf_cnt", OVF_CNT, 0);
    check_val("rst_err", ERR, 0);
    RST_N = 1'b1;
    tick();

    // 31+1=32: C=1 Z=1 N=0 V=0 -> {V,N,Z,C}=0011
    OUT_READY = 1'b1;
    drive(1, 5'd31, 5'd1, 6'd32);
    tick();
    check_val("v1_out_valid", OUT_VALID, 1);
    check_val("v1_out_s", OUT_S, 32);
    check_val("v1_flags", OUT_FLAGS, 4'b0011);
    check_val("v1_res_cnt", RES_CNT, 1);
    check_val("v1_carry_cnt", CARRY_CNT, 1);

    // 15+1=16: V=1 N=1 Z=0 C=0 -> 1100
    drive(1, 5'd15, 5'd1, 6'd16);
    tick();
    check_val("v2_out_s", OUT_S, 16);
    check_val("v2_flags", OUT_FLAGS, 4'b1100);
    check_val("v2_ovf_cnt", OVF_CNT, 1);
    check_val("v2_res_cnt", RES_CNT, 2);
    drive(0, 0, 0, 0);
    tick();
    check_val("v2_drained", OUT_VALID, 0);

    // Backpressure: two accepts fill the stage, third is held
    OUT_READY = 1'b0;
    drive(1, 5'd1, 5'd1, 6'd2);
    tick();
    check_val("bp_ready_1", IN_READY, 1);
    drive(1, 5'd2, 5'd2, 6'd4);
    tick();
    check_val("bp_ready_full", IN_READY, 0);
    drive(1, 5'd3, 5'd3, 6'd6);
    tick();
    check_val("bp_still_full", IN_READY, 0);
    check_val("bp_head_2", OUT_S, 2);
    check_val("bp_res_cnt", RES_CNT, 4);
    OUT_READY = 1'b1;
    tick();
    check_val("bp_head_4", OUT_S, 4);
    check_val("bp_ready_after_pop", IN_READY, 1);
    tick();
    check_val("bp_head_6", OUT_S, 6);
    check_val("bp_res_cnt_5", RES_CNT, 5);
    drive(0, 0, 0, 0);
    tick();
    check_val("bp_empty", OUT_VALID, 0);
    check_val("bp_err", ERR, 0);

    // Mismatch: 3+4 reported as 8
    drive(1, 5'd3, 5'd4, 6'd8);
    tick();
    check_val("mm_err", ERR, 1);
    check_val("mm_out_s", OUT_S, 8);
    check_val("mm_flags", OUT_FLAGS, 4'b0000);
    drive(0, 0, 0, 0);
    tick();
    check_val("mm_err_sticky", ERR, 1);

    // CLR with a correct push: clear then count it
    CLR = 1'b1;
    drive(1, 5'd3, 5'd4, 6'd7);
    tick();
    CLR = 1'b0;
    drive(0, 0, 0, 0);
    check_val("clr_err", ERR, 0);
    check_val("clr_res_cnt", RES_CNT, 1);
    check_val("clr_carry_cnt", CARRY_CNT, 0);
    check_val("clr_ovf_cnt", OVF_CNT, 0);
    check_val("clr_out_s", OUT_S, 7);
    tick();

    // Saturation: 16+16=32 has C=1 and V=1; 300 pushes saturate all counters
    drive(1, 5'd16, 5'd16, 6'd32);
    for (int i = 0; i < 300; i++) tick();
    drive(0, 0, 0, 0);
    check_val("sat_res_cnt", RES_CNT, 255);
    check_val("sat_carry_cnt", CARRY_CNT, 255);
    check_val("sat_ovf_cnt", OVF_CNT, 255);
    check_val("sat_flags", OUT_FLAGS, 4'b1011);
    tick();

    // Reset mid-operation with two buffered entries
    OUT_READY = 1'b0;
    drive(1, 5'd1, 5'd1, 6'd2);
    tick();
    drive(1, 5'd2, 5'd2, 6'd4);
    tick();
    drive(0, 0, 0, 0);
    check_val("mid_full", IN_READY, 0);
    #2 RST_N = 1'b0;
    #1;
    check_val("mid_async_valid", OUT_VALID, 0);
    check_val("mid_async_ready", IN_READY, 1);
    check_val("mid_async_out_s", OUT_S, 0);
    check_val("mid_async_res_cnt", RES_CNT, 0);
    tick();
    RST_N = 1'b1;
    tick();
    check_val("post_rst_valid", OUT_VALID, 0);
    check_val("post_rst_carry", CARRY_CNT, 0);
    check_val("post_rst_ovf", OVF_CNT, 0);
    check_val("post_rst_err", ERR, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
